// File: rtl/ddr_rd_burst_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_burst_unpacker_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               DDR read-burst unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_rd_burst_unpacker_pkg;

    localparam int c_DDR_DATA_WIDTH = 128;
    localparam int c_DATA_WIDTH     = 16;
    localparam int c_LANES          = c_DDR_DATA_WIDTH / c_DATA_WIDTH;
    localparam int c_BEAT_DEPTH     = 8;
    localparam int c_WORD_CNT_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int unsigned ceil_div(input int unsigned words, input int unsigned lanes);
        return (words + lanes - 32'd1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_rd_burst_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_burst_unpacker_if
// Description : Request, beat input, word output and status bundle of the
//               unpacker; i_/o_ names are from the unpacker's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_rd_burst_unpacker_if
    import ddr_rd_burst_unpacker_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = c_DDR_DATA_WIDTH,
    parameter int DATA_WIDTH     = c_DATA_WIDTH,
    parameter int BEAT_DEPTH     = c_BEAT_DEPTH,
    parameter int WORD_CNT_WIDTH = c_WORD_CNT_WIDTH
) ();

    localparam int c_FREE_W = $clog2(BEAT_DEPTH + 1);

    logic                      i_start;
    logic [WORD_CNT_WIDTH-1:0] i_start_words;
    logic                      i_in_valid;
    logic [DDR_DATA_WIDTH-1:0] i_in_data;
    logic                      i_out_ready;
    logic                      o_out_valid;
    logic [DATA_WIDTH-1:0]     o_out_data;
    logic                      o_out_last;
    logic                      o_busy;
    logic                      o_done;
    logic [c_FREE_W-1:0]       o_free_beats;
    logic                      o_overflow;

    modport slave (
        input  i_start, i_start_words, i_in_valid, i_in_data, i_out_ready,
        output o_out_valid, o_out_data, o_out_last, o_busy, o_done, o_free_beats, o_overflow
    );

    modport master (
        output i_start, i_start_words, i_in_valid, i_in_data, i_out_ready,
        input  o_out_valid, o_out_data, o_out_last, o_busy, o_done, o_free_beats, o_overflow
    );

endinterface
`default_nettype wire

// File: rtl/ddr_rd_burst_unpacker_beat_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : beat_sync_fifo
// Description : Single-clock beat FIFO with show-ahead head; a push into a
//               full FIFO is legal when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_sync_fifo
    import ddr_rd_burst_unpacker_pkg::*;
#(
    parameter int WIDTH = c_DDR_DATA_WIDTH,
    parameter int DEPTH = c_BEAT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_CW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    // When full, wr_ptr aliases rd_ptr: the head is read combinationally
    // before the write lands, so push-on-pop-while-full is safe.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_rd_burst_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_burst_unpacker
// Description : Buffers 128-bit DDR read beats and serialises them into
//               DATA_WIDTH words, trimming padding lanes of the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_rd_burst_unpacker
    import ddr_rd_burst_unpacker_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = c_DDR_DATA_WIDTH,
    parameter int DATA_WIDTH     = c_DATA_WIDTH,
    parameter int BEAT_DEPTH     = c_BEAT_DEPTH,
    parameter int WORD_CNT_WIDTH = c_WORD_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    ddr_rd_burst_unpacker_if.slave  bus
);

    localparam int c_NUM_LANES = DDR_DATA_WIDTH / DATA_WIDTH;
    localparam int c_LANE_W    = $clog2(c_NUM_LANES);
    localparam int c_FREE_W    = $clog2(BEAT_DEPTH + 1);

    state_t                                 r_state;
    logic [WORD_CNT_WIDTH-1:0]              r_words_left;
    logic [WORD_CNT_WIDTH-1:0]              r_beats_expected;
    logic [c_LANE_W-1:0]                    r_lane_idx;
    logic                                   r_overflow;

    logic [DDR_DATA_WIDTH-1:0]              w_head;
    logic [c_NUM_LANES-1:0][DATA_WIDTH-1:0] w_head_lanes;
    logic [c_FREE_W-1:0]                    w_count;
    logic                                   w_empty;
    logic                                   w_out_valid;
    logic                                   w_hs;
    logic                                   w_last_word;
    logic                                   w_pop;
    logic                                   w_push;

    beat_sync_fifo #(
        .WIDTH (DDR_DATA_WIDTH),
        .DEPTH (BEAT_DEPTH)
    ) u_beat_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.i_in_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign w_head_lanes = w_head;
    assign w_out_valid  = (r_state == ST_STREAM) && !w_empty;
    assign w_hs         = w_out_valid && bus.i_out_ready;
    assign w_last_word  = (r_words_left == WORD_CNT_WIDTH'(1));
    // Head beat retires after its top lane or after the burst's last word.
    assign w_pop        = w_hs && ((r_lane_idx == c_LANE_W'(c_NUM_LANES - 1)) || w_last_word);
    assign w_push       = bus.i_in_valid && (r_state == ST_STREAM) && (r_beats_expected != '0)
                          && ((w_count < c_FREE_W'(BEAT_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_words_left     <= '0;
            r_beats_expected <= '0;
            r_lane_idx       <= '0;
            r_overflow       <= 1'b0;
        end else begin
            if (bus.i_in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_beats_expected <= r_beats_expected - WORD_CNT_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_words_left     <= bus.i_start_words;
                        r_beats_expected <= WORD_CNT_WIDTH'(ceil_div(32'(bus.i_start_words), c_NUM_LANES));
                        r_lane_idx       <= '0;
                        r_state          <= (bus.i_start_words != '0) ? ST_STREAM : ST_DONE;
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        r_words_left <= r_words_left - WORD_CNT_WIDTH'(1);
                        r_lane_idx   <= w_pop ? '0 : r_lane_idx + c_LANE_W'(1);
                        if (w_last_word) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_out_valid  = w_out_valid;
    assign bus.o_out_data   = w_out_valid ? w_head_lanes[r_lane_idx] : '0;
    assign bus.o_out_last   = w_out_valid && w_last_word;
    assign bus.o_busy       = (r_state != ST_IDLE);
    assign bus.o_done       = (r_state == ST_DONE);
    assign bus.o_free_beats = c_FREE_W'(BEAT_DEPTH) - w_count;
    assign bus.o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_burst_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_rd_burst_unpacker
// Description : Self-checking bench; a word-queue reference model predicts
//               every output each cycle for directed and random bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_burst_unpacker;
    import ddr_rd_burst_unpacker_pkg::*;

    localparam int DW  = 16;
    localparam int BW  = 128;
    localparam int LN  = 8;
    localparam int DEP = 8;
    localparam int CW  = 10;

    typedef struct {
        bit            rs;
        bit            st;
        int            sw;
        bit            iv;
        logic [BW-1:0] d;
        bit            rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_rd_burst_unpacker_if #(
        .DDR_DATA_WIDTH(BW), .DATA_WIDTH(DW), .BEAT_DEPTH(DEP), .WORD_CNT_WIDTH(CW)
    ) bus ();

    ddr_rd_burst_unpacker #(
        .DDR_DATA_WIDTH(BW), .DATA_WIDTH(DW), .BEAT_DEPTH(DEP), .WORD_CNT_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt;
    stim_t q[$];

    // Reference model: buffered words in output order, words left in each buffered beat.
    int            m_state;   // 0 idle, 1 streaming, 2 done
    int            m_left;
    int            m_to_fill;
    bit            m_ovf;
    logic [DW-1:0] m_wq[$];
    int            m_bq[$];

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic stim_t mk(bit rs, bit st, int sw, bit iv, logic [BW-1:0] d, bit rdy);
        stim_t s;
        s.rs = rs; s.st = st; s.sw = sw; s.iv = iv; s.d = d; s.rdy = rdy;
        return s;
    endfunction

    function automatic stim_t idle(bit rdy);
        return mk(1'b0, 1'b0, 0, 1'b0, rand_beat(), rdy);
    endfunction

    function automatic stim_t beat(logic [BW-1:0] d, bit rdy);
        return mk(1'b0, 1'b0, 0, 1'b1, d, rdy);
    endfunction

    function automatic stim_t start(int sw, bit rdy);
        return mk(1'b0, 1'b1, sw, 1'b0, rand_beat(), rdy);
    endfunction

    function automatic stim_t rst_cyc();
        return mk(1'b1, 1'b0, 0, 1'b0, '0, 1'b0);
    endfunction

    function automatic logic [24:0] exp_vec();
        bit            v;
        logic [DW-1:0] d;
        v = (m_state == 1) && (m_wq.size() > 0);
        d = v ? m_wq[0] : 16'h0;
        return {v, v && (m_left == 1), m_state != 0, m_state == 2, m_ovf, 4'(DEP - m_bq.size()), d};
    endfunction

    function automatic logic [24:0] obs_vec();
        return {bus.o_out_valid, bus.o_out_last, bus.o_busy, bus.o_done, bus.o_overflow,
                bus.o_free_beats, bus.o_out_valid ? bus.o_out_data : 16'h0};
    endfunction

    task automatic model_reset();
        m_state = 0; m_left = 0; m_to_fill = 0; m_ovf = 1'b0;
        m_wq.delete(); m_bq.delete();
    endtask

    task automatic model_step(input stim_t s);
        bit hs, popb, acc;
        int n;
        if (s.rs) begin
            model_reset();
            return;
        end
        hs   = (m_state == 1) && (m_wq.size() > 0) && s.rdy;
        popb = hs && (m_bq[0] == 1);
        acc  = s.iv && (m_state == 1) && (m_to_fill > 0) && ((m_bq.size() < DEP) || popb);
        if (s.iv && !acc) m_ovf = 1'b1;
        if (hs) begin
            void'(m_wq.pop_front());
            m_bq[0] = m_bq[0] - 1;
            if (m_bq[0] == 0) void'(m_bq.pop_front());
            m_left--;
        end
        if (acc) begin
            n = (m_to_fill < LN) ? m_to_fill : LN;
            for (int i = 0; i < n; i++) m_wq.push_back(s.d[i*DW +: DW]);
            m_bq.push_back(n);
            m_to_fill -= n;
        end
        case (m_state)
            0: if (s.st) begin
                m_left    = s.sw;
                m_to_fill = s.sw;
                m_state   = (s.sw != 0) ? 1 : 2;
            end
            1: if (hs && m_left == 0) m_state = 2;
            default: m_state = 0;
        endcase
    endtask

    task automatic apply(input stim_t s);
        rst               = s.rs;
        bus.i_start       = s.st;
        bus.i_start_words = CW'(s.sw);
        bus.i_in_valid    = s.iv;
        bus.i_in_data     = s.d;
        bus.i_out_ready   = s.rdy;
    endtask

    task automatic test_reset();
        q.delete();
        model_reset();
        q.push_back(rst_cyc()); q.push_back(rst_cyc());
        q.push_back(idle(1'b1)); q.push_back(idle(1'b0));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus.o_free_beats !== 4'd8) $display("FAIL reset_free_beats: got %0d expected 8", bus.o_free_beats);
        else n_pass++;
    endtask

    task automatic test_burst16();
        logic [BW-1:0] b0, b1;
        for (int k = 0; k < LN; k++) begin
            b0[k*DW +: DW] = 16'(k);
            b1[k*DW +: DW] = 16'(k + 8);
        end
        q.delete(); hs_cnt = 0;
        q.push_back(start(16, 1'b1)); q.push_back(beat(b0, 1'b1)); q.push_back(beat(b1, 1'b1));
        for (int k = 0; k < 20; k++) q.push_back(idle(1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL burst16 cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 16 || bus.o_free_beats !== 4'd8)
            $display("FAIL burst16_end: got words=%0d free=%0d expected words=16 free=8", hs_cnt, bus.o_free_beats);
        else n_pass++;
    endtask

    task automatic test_partial_beat();
        q.delete(); hs_cnt = 0;
        q.push_back(start(10, 1'b1));
        q.push_back(beat(rand_beat(), 1'($urandom_range(0, 1))));
        q.push_back(beat(rand_beat(), 1'($urandom_range(0, 1))));
        for (int k = 0; k < 40; k++) q.push_back(idle($urandom_range(0, 3) != 0));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL partial cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 10 || bus.o_free_beats !== 4'd8 || bus.o_overflow !== 1'b0)
            $display("FAIL partial_end: got words=%0d free=%0d ovf=%0b expected 10/8/0", hs_cnt, bus.o_free_beats, bus.o_overflow);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        q.delete(); hs_cnt = 0;
        q.push_back(start(64, 1'b0));
        for (int k = 0; k < 8; k++) q.push_back(beat(rand_beat(), 1'b0));
        q.push_back(idle(1'b0));
        for (int k = 0; k < 80; k++) q.push_back(idle(1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL backpressure cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 9) begin
                n_checks++;
                if (bus.o_free_beats !== 4'd0 || bus.o_overflow !== 1'b0)
                    $display("FAIL backpressure_full: got free=%0d ovf=%0b expected free=0 ovf=0", bus.o_free_beats, bus.o_overflow);
                else n_pass++;
            end
            if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 64) $display("FAIL backpressure_words: got %0d expected 64", hs_cnt);
        else n_pass++;
    endtask

    task automatic test_drop_when_full();
        q.delete(); hs_cnt = 0;
        q.push_back(start(72, 1'b0));
        for (int k = 0; k < 9; k++) q.push_back(beat(rand_beat(), 1'b0));
        for (int k = 0; k < 7; k++) q.push_back(idle(1'b1));
        q.push_back(beat(rand_beat(), 1'b1));
        for (int k = 0; k < 90; k++) q.push_back(idle(1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL drop_full cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 10) begin
                n_checks++;
                if (bus.o_overflow !== 1'b1) $display("FAIL drop_full_ovf: got %0b expected 1", bus.o_overflow);
                else n_pass++;
            end
            if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 72 || bus.o_busy !== 1'b0 || bus.o_overflow !== 1'b1)
            $display("FAIL drop_full_end: got words=%0d busy=%0b ovf=%0b expected 72/0/1", hs_cnt, bus.o_busy, bus.o_overflow);
        else n_pass++;
    endtask

    task automatic test_idle_beat_and_busy_start();
        q.delete(); hs_cnt = 0;
        q.push_back(rst_cyc());
        q.push_back(beat(rand_beat(), 1'b1));
        q.push_back(idle(1'b1));
        q.push_back(start(8, 1'b1));
        q.push_back(beat(rand_beat(), 1'b1));
        q.push_back(start(3, 1'b1));
        for (int k = 0; k < 15; k++) q.push_back(idle(1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL idle_beat cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (bus.o_overflow !== 1'b1 || bus.o_out_valid !== 1'b0)
                    $display("FAIL idle_beat_ovf: got ovf=%0b valid=%0b expected ovf=1 valid=0", bus.o_overflow, bus.o_out_valid);
                else n_pass++;
            end
            if (!q[i].rs && bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 8) $display("FAIL busy_start_words: got %0d expected 8", hs_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        q.delete(); hs_cnt = 0;
        q.push_back(rst_cyc());
        q.push_back(start(16, 1'b1));
        q.push_back(beat(rand_beat(), 1'b1));
        q.push_back(beat(rand_beat(), 1'b1));
        q.push_back(idle(1'b1)); q.push_back(idle(1'b1));
        q.push_back(mk(1'b1, 1'b0, 0, 1'b0, '0, 1'b1));
        q.push_back(start(8, 1'b1));
        q.push_back(beat(rand_beat(), 1'b1));
        for (int k = 0; k < 15; k++) q.push_back(idle(1'b1));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL mid_reset cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 6) begin
                n_checks++;
                if (hs_cnt !== 3) $display("FAIL mid_reset_pre: got %0d words expected 3", hs_cnt);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if (obs_vec() !== {5'b0, 4'd8, 16'h0} || bus.o_out_data !== 16'h0)
                    $display("FAIL mid_reset_values: got %h expected %h", obs_vec(), {5'b0, 4'd8, 16'h0});
                else n_pass++;
            end
            if (q[i].rs) hs_cnt = 0;
            else if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== 8) $display("FAIL mid_reset_rerun: got %0d words expected 8", hs_cnt);
        else n_pass++;
    endtask

    task automatic test_random_bursts();
        int total, sw, nb;
        q.delete(); hs_cnt = 0; total = 0;
        for (int b = 0; b < 6; b++) begin
            sw = $urandom_range(0, 40);
            nb = (sw + LN - 1) / LN;
            total += sw;
            q.push_back(start(sw, $urandom_range(0, 1) != 0));
            for (int k = 0; k < nb; k++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) q.push_back(idle($urandom_range(0, 3) != 0));
                if ($urandom_range(0, 5) == 0) q.push_back(beat(rand_beat(), $urandom_range(0, 3) != 0));
                q.push_back(beat(rand_beat(), $urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 3) == 0) q.push_back(beat(rand_beat(), 1'b1));
            for (int k = 0; k < 100; k++) q.push_back(idle($urandom_range(0, 3) != 0));
        end
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
            model_step(q[i]);
            @(posedge clk); #1;
        end
        n_checks++;
        if (hs_cnt !== total) $display("FAIL random_words: got %0d expected %0d", hs_cnt, total);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_burst16();
        test_partial_beat();
        test_backpressure();
        test_drop_when_full();
        test_idle_beat_and_busy_start();
        test_reset_mid_burst();
        test_random_bursts();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
